// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - parametrised ID-stage hazard unit: stall, flush, forwarding selects, counters
module hazard_scoreboard #(
    parameter int REG_AW       = 5,
    parameter int NUM_STAGES   = 3,
    parameter int FWD_EN       = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32,
    parameter int SEL_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_we,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_sel_rs1,
    output logic [SEL_W-1:0]  fwd_sel_rs2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] MASK_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [NUM_STAGES:1] sb_valid;
    logic [NUM_STAGES:1] sb_we;
    logic [NUM_STAGES:1] sb_load;
    logic [REG_AW-1:0]   sb_rd [1:NUM_STAGES];
    logic [1:0]          mask_cnt;

    logic [NUM_STAGES:1] hit1;
    logic [NUM_STAGES:1] hit2;
    logic [SEL_W-1:0]    sel1;
    logic [SEL_W-1:0]    sel2;
    logic                hazard;
    logic                issue;

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            hit1[k] = id_rs1_used && (id_rs1 != '0) && sb_valid[k] && sb_we[k] && (sb_rd[k] == id_rs1);
            hit2[k] = id_rs2_used && (id_rs2 != '0) && sb_valid[k] && sb_we[k] && (sb_rd[k] == id_rs2);
        end
    end

    // Scan oldest to youngest so the youngest match overwrites the select last.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (hit1[k]) sel1 = SEL_W'(k);
            if (hit2[k]) sel2 = SEL_W'(k);
        end
    end

    assign hazard      = (FWD_EN != 0) ? (sb_load[1] && (hit1[1] || hit2[1]))
                                       : ((|hit1) || (|hit2));
    assign flush       = ex_redirect || (mask_cnt != 2'd0);
    assign stall       = id_valid && hazard && !flush;
    assign issue       = id_valid && !stall && !flush;
    assign fwd_sel_rs1 = (FWD_EN != 0) ? sel1 : '0;
    assign fwd_sel_rs2 = (FWD_EN != 0) ? sel2 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid  <= '0;
            sb_we     <= '0;
            sb_load   <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) sb_rd[k] <= '0;
            mask_cnt  <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // x0 writes are dropped at entry so they can never be matched later.
            sb_valid[1] <= issue;
            sb_we[1]    <= id_rf_we && (id_rd != '0);
            sb_load[1]  <= id_is_load;
            sb_rd[1]    <= id_rd;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_we[k]    <= sb_we[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            if (ex_redirect)
                mask_cnt <= MASK_LOAD;
            else if (mask_cnt != 2'd0)
                mask_cnt <= mask_cnt - 2'd1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the pipelined core. Replaces the fixed three-stage stall-only detector with a configurable depth.
- Tracks in-flight register writes in a shift-register scoreboard and generates several controls: stall, flush, forwarding selects, a post-redirect fetch mask, and performance counters.
- Sits beside the ID stage. It consumes decoded operands and EX-stage redirects, and drives PC, IF_ID and ID_EX hold/squash controls plus the EX operand muxes.

Parameters:
- REG_AW, 5, register address width.
- NUM_STAGES, 3, tracked stages after ID up to and including WB. Entry 1 is EX; entry NUM_STAGES writes the RF this cycle. Legal range is 2..8.
- FWD_EN, 1, mode select. 1 means forward from all entries and stall only on load-use. 0 means stall-only: stall on any match.
- FLUSH_CYCLES, 2, cycles of squash after a redirect, including the redirect cycle. Legal range is 1..4.
- CNT_W, 32, width of the performance counters.
- SEL_W, $clog2(NUM_STAGES+1), width of the forwarding selects.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  a real instruction is in ID
- id_rs1  in  REG_AW  source register 1
- id_rs2  in  REG_AW  source register 2
- id_rs1_used  in  1  rs1 is read
- id_rs2_used  in  1  rs2 is read
- id_rd  in  REG_AW  destination register
- id_rf_we  in  1  instruction writes the RF
- id_is_load  in  1  instruction is a load (result available only from MEM onward)
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- stall  out  1  hold PC and IF_ID, insert a bubble into ID_EX
- flush  out  1  squash IF_ID and ID_EX
- fwd_sel_rs1  out  SEL_W  0 = RF value, k = result of entry k
- fwd_sel_rs2  out  SEL_W  same encoding, for rs2
- stall_cnt  out  CNT_W  cycles with stall=1
- flush_cnt  out  CNT_W  number of redirects accepted

Behaviour:
- Scoreboard: entries 1..NUM_STAGES, each holding {valid, rd, we, is_load}.
  - Every rising clk, entry k+1 takes the contents of entry k.
  - Entry 1 loads the ID fields only when issue = id_valid & !stall & !flush. Otherwise entry 1 loads a bubble (valid=0).
  - There is no hold in tracked stages; the EX onward stages never stall.
- Flush:
  - flush = ex_redirect | (mask_cnt != 0).
  - mask_cnt is a down-counter. It loads FLUSH_CYCLES-1 on ex_redirect and decrements while nonzero.
  - A redirect arriving while mask_cnt != 0 reloads the counter.
  - flush_cnt increments on each cycle with ex_redirect=1.
- Match: source s (rs1 or rs2) matches entry k when all of the following hold: s_used, s != 0, entry valid, entry we, entry rd == s. The youngest matching entry (lowest k) wins.
- FWD_EN=1:
  - fwd_sel = k of the youngest match, or 0 if there is no match.
  - hazard if the youngest match is k=1 with is_load=1.
  - While a load-use hazard is stalling, fwd_sel still reports k=1. Consumers ignore fwd_sel during a stall.
- FWD_EN=0:
  - fwd_sel is always 0.
  - hazard if any entry 1..NUM_STAGES matches.
- stall = id_valid & hazard & !flush. Flush has priority over stall; the squashed instruction needs no stall.
- Counters: stall_cnt and flush_cnt saturate at 2^CNT_W-1 and never wrap.
- Latency: stall, flush and fwd_sel are combinational from the inputs and the current scoreboard. Scoreboard and counters update one cycle later.
- Reset (rst_n=0, asynchronous):
  - All entries go invalid; mask_cnt=0; both counters go to 0.
  - Consequently stall=0, fwd_sel_rs1=fwd_sel_rs2=0, and flush=ex_redirect (must be held 0 by upstream during reset).
  - Reset mid-stall or mid-flush drops all tracked state. There is no resumption.
- x0: never tracked as a hazard, regardless of id_rd.

Test Plan:
- FWD_EN=0, NUM_STAGES=3: issue "addi x5" with rd=5, then an ID instruction with rs1=5 -> stall=1 for exactly 3 cycles; issue proceeds on the 4th; stall_cnt=3.
- FWD_EN=1: issue "add x6" (rd=6, not a load), next ID reads rs2=6 -> stall=0 and fwd_sel_rs2=1. One cycle later, with a bubble between, a reader of x6 gets fwd_sel_rs2=2.
- FWD_EN=1 load-use: issue a load to x7, next ID reads rs1=7 -> stall=1 for 1 cycle, then fwd_sel_rs1=2 with stall=0; stall_cnt=1.
- Two writers of x8 in entries 1 and 2 (neither a load), ID reads rs1=8 -> fwd_sel_rs1=1, the youngest entry.
- ex_redirect pulse with FLUSH_CYCLES=2 while a hazard exists -> flush=1 for 2 cycles and stall=0 throughout; entry 1 holds a bubble; flush_cnt=1.
- Producer targeting rd=0, then an ID read of rs1=0 -> stall=0 and fwd_sel=0. Asserting rst_n=0 during a stall -> stall=0 immediately and all counters read 0.
